// File: rtl/firebird7_in_gate1_tessent_tdr_mux_ctrl_w3.sv
// IJTAG TDR driving the gate1 w3 mux select/data, with capture of the mux output and a sticky mismatch flag.
// Optional macro FIREBIRD7_IN_GATE1_TDR_SO_RETIME_EN adds a falling-edge lockup flop on ijtag_so.
module firebird7_in_gate1_tessent_tdr_mux_ctrl_w3 #(
    parameter int DATA_W = 3
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              ijtag_sel,
    input  logic              ijtag_ce,
    input  logic              ijtag_se,
    input  logic              ijtag_ue,
    input  logic              ijtag_si,
    output logic              ijtag_so,
    input  logic [DATA_W-1:0] observe_data,
    output logic              ijtag_select,
    output logic [DATA_W-1:0] ijtag_data_out
);
    localparam int L = DATA_W + 2;

    logic [L-1:0]      sr_q,   sr_d;
    logic              sel_q,  sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mism_q, mism_d;
    logic              mism_set_s, mism_clr_s;

    // Next-state for the scan chain, update registers and sticky mismatch flag
    always_comb begin
        sr_d       = sr_q;
        sel_d      = sel_q;
        data_d     = data_q;
        mism_set_s = sel_q & (observe_data != data_q);
        mism_clr_s = ijtag_sel & ijtag_ue;
        mism_d     = mism_set_s | (mism_q & ~mism_clr_s);
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d = {mism_q, observe_data, sel_q};
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[L-1:1]};
            end else begin
                sr_d = sr_q;
            end
            // Update reads the pre-edge chain, so it is unaffected by a same-edge capture/shift
            if (ijtag_ue) begin
                sel_d  = sr_q[0];
                data_d = sr_q[DATA_W:1];
            end else begin
                sel_d  = sel_q;
                data_d = data_q;
            end
        end else begin
            sr_d   = sr_q;
            sel_d  = sel_q;
            data_d = data_q;
        end
    end

    // State registers on the rising TCK edge, cleared asynchronously by ijtag_reset
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr_q   <= {L{1'b0}};
            sel_q  <= 1'b0;
            data_q <= {DATA_W{1'b0}};
            mism_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            sel_q  <= sel_d;
            data_q <= data_d;
            mism_q <= mism_d;
        end
    end

    assign ijtag_select   = sel_q;
    assign ijtag_data_out = data_q;

`ifdef FIREBIRD7_IN_GATE1_TDR_SO_RETIME_EN
    logic so_q;

    // Lockup flop: scan-out moves half a cycle after the shift edge
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            so_q <= 1'b0;
        end else begin
            so_q <= sr_q[0];
        end
    end

    assign ijtag_so = so_q;
`else
    assign ijtag_so = sr_q[0];
`endif

endmodule
